// File: rtl/bias_accum_child.sv
// bias_accum_child: accumulates K-tile partial sums, adds bias on the last beat, saturates and emits one result strobe.
module bias_accum_child #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 25,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ba_valid_in,
  input  logic [DATA_WIDTH-1:0] ba_data_in,
  input  logic [DATA_WIDTH-1:0] ba_bias_in,
  input  logic [CNT_WIDTH-1:0]  ba_num_tiles_in,
  input  logic                  ba_flush_in,
  output logic [DATA_WIDTH-1:0] ba_data_out,
  output logic                  ba_valid_out,
  output logic                  ba_busy_out,
  output logic                  ba_sat_out
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic signed [ACC_WIDTH-1:0] max_v = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] min_v = -max_v - ACC_WIDTH'(1);
  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc, data_x, bias_x, part, sum;
  logic [CNT_WIDTH-1:0]         cnt, ntiles, first_nt;
  logic                         last, hi, lo;
  logic [DATA_WIDTH-1:0]        sat_data;
  always_comb begin
    data_x   = {{(ACC_WIDTH-DATA_WIDTH){ba_data_in[DATA_WIDTH-1]}}, ba_data_in};
    bias_x   = {{(ACC_WIDTH-DATA_WIDTH){ba_bias_in[DATA_WIDTH-1]}}, ba_bias_in};
    first_nt = ba_num_tiles_in == '0 ? CNT_WIDTH'(1) : ba_num_tiles_in;
    last     = state == IDLE ? first_nt == CNT_WIDTH'(1) : cnt == ntiles - CNT_WIDTH'(1);
    part     = acc + data_x;
    sum      = part + bias_x;
    hi       = sum > max_v;
    lo       = sum < min_v;
    sat_data = hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : sum[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      ntiles       <= '0;
      ba_data_out  <= '0;
      ba_valid_out <= 1'b0;
      ba_sat_out   <= 1'b0;
    end else begin
      ba_valid_out <= 1'b0;
      ba_data_out  <= '0;
      if (ba_flush_in) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else if (ba_valid_in && last) begin
        state        <= IDLE;
        acc          <= '0;
        cnt          <= '0;
        ba_valid_out <= 1'b1;
        ba_data_out  <= sat_data;
        ba_sat_out   <= ba_sat_out | hi | lo;
      end else if (ba_valid_in) begin
        state <= ACCUM;
        acc   <= part;
        cnt   <= cnt + CNT_WIDTH'(1);
        if (state == IDLE) ntiles <= first_nt;
      end
    end
  end
  assign ba_busy_out = state == ACCUM;
endmodule

// File: doc/bias_accum_child.md
# bias_accum_child

Per-column post-systolic stage that sits directly upstream of the leaky-ReLU stage in the vector processing path. It accumulates the K-tile partial sums arriving for one output element, adds that column's bias on the final partial sum, saturates the result to 16-bit fixed point, and emits one valid beat per completed element. All data is signed fixed point; defaults are Q8.8.

## Interface
- DATA_WIDTH, 16: width of the data, bias and output words (signed fixed point).
- ACC_WIDTH, 25: internal accumulator width. Must be at least DATA_WIDTH + CNT_WIDTH + 1.
- CNT_WIDTH, 8: width of the tile count and of the internal beat counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- ba_valid_in  in  1  partial-sum beat present.
- ba_data_in  in  DATA_WIDTH  signed partial sum.
- ba_bias_in  in  DATA_WIDTH  signed bias; sampled only on a group's last beat.
- ba_num_tiles_in  in  CNT_WIDTH  partial sums per element; sampled only on a group's first beat. 0 is treated as 1.
- ba_flush_in  in  1  abandons the group in progress.
- ba_data_out  out  DATA_WIDTH  saturated sum (feeds lr_data_in).
- ba_valid_out  out  1  one-cycle result strobe (feeds lr_valid_in).
- ba_busy_out  out  1  high while the FSM is in ACCUM.
- ba_sat_out  out  1  sticky saturation flag.

## Operation
- Two states:
  - IDLE: acc = 0, cnt = 0.
  - ACCUM: mid-group.
- IDLE with valid_in, no flush:
  - Latch ntiles = max(num_tiles_in, 1).
  - If ntiles == 1, the beat is both first and last: emit.
  - Otherwise: acc <= sext(data_in), cnt <= 1, go to ACCUM.
- ACCUM with valid_in, no flush:
  - If cnt == ntiles-1, this is the last beat: emit, then return to IDLE.
  - Otherwise: acc += sext(data_in), cnt++.
- Emit, in the cycle the last beat is accepted:
  - sum = acc + sext(data_in) + sext(bias_in), computed at ACC_WIDTH.
  - Register sat(sum) into data_out and assert valid_out.
  - acc <= 0, cnt <= 0, state <= IDLE.
- Saturation:
  - sum > 2^(DATA_WIDTH-1)-1 clamps to 0x7FFF.
  - sum < -2^(DATA_WIDTH-1) clamps to 0x8000.
  - Either clamp sets sat_out. sat_out clears only on reset.
- Gaps: cycles with valid_in low hold acc, cnt and state. A group may span any number of idle cycles.
- Flush:
  - Any state: acc <= 0, cnt <= 0, state <= IDLE, no output produced.
  - Flush together with valid_in: flush wins and the beat is discarded.
- Mid-group input changes: num_tiles_in is ignored after the first beat. bias_in is ignored on non-last beats.
- No backpressure: the downstream stage always accepts.

## Timing
- Latency: 1 cycle from acceptance of the last beat to valid_out.
- Strobe width: valid_out is high for exactly one cycle per group.
- Idle output: when valid_out is low, data_out is 0 (matches downstream zeroing convention).
- Throughput: a group's last beat and the next group's first beat may arrive in consecutive cycles with no bubble. With ntiles = 1, one result per cycle.
- busy_out: registered; high from the cycle after an ACCUM-entering first beat until the cycle after the last beat.
- Reset (rst low at a clock edge):
  - data_out = 0, valid_out = 0, busy_out = 0, sat_out = 0.
  - State IDLE, acc = 0, cnt = 0.
  - A partial group is discarded.
  - Reset overrides valid_in and flush_in.

## Test plan
- Single tile: ntiles=1, data 0x0180, bias 0x0040 -> next cycle data_out=0x01C0, valid_out=1 for one cycle, then data_out=0.
- Three tiles with gaps: data 0x0100, (2 idle cycles), 0x0200, (1 idle cycle), 0xFF00, bias 0x0080 on the third beat -> data_out=0x0280 one cycle after the third beat. valid_out stays low during all earlier cycles. busy_out is high across the group.
- Saturation, positive: ntiles=2, data 0x7000, 0x7000, bias 0 -> data_out=0x7FFF, sat_out=1 and stays 1.
- Saturation, negative: ntiles=2, data 0x9000, 0x9000 -> data_out=0x8000.
- Flush: ntiles=4, two beats of 0x0100, then flush together with a valid beat -> no valid_out, busy_out drops. Next group ntiles=1, data 0x0010, bias 0 -> 0x0010, with no stale accumulation.
- Reset and back-to-back:
  - Drive rst low after 2 of 3 beats -> all outputs 0 next cycle.
  - Then ntiles=0 (treated as 1) with beats 0x0001, 0x0002, 0x0003 on consecutive cycles, bias 0 -> outputs 0x0001, 0x0002, 0x0003 on consecutive cycles.
